rv32im_lsu: RTL and testbench

Load/store sequencer sitting between the execute stage and `rv32im_memory_nopipe`. It accepts one RV32 load or store per request and traps misaligned or illegal-width accesses without touching the bus. Legal accesses are issued to the memory stage as a single-cycle `data_ready` pulse, with store data replicated across byte lanes. Load data is extracted and sign- or zero-extended, and bus errors and hung transactions are recovered by pulsing the memory stage's clear.

---
 rtl/rv32im_lsu_if.sv | 24 ++
 rtl/rv32im_lsu.sv | 236 +++++++++++++++++++++++
 tb/tb_rv32im_lsu.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rv32im_lsu_if.sv
// Bus between the load/store sequencer and the non-pipelined memory stage.
// Field mapping to the memory stage: data_ready -> data_ready_i,
// clear -> clear_i, req_active <- ctrl_req_o, err <- err_o, rdata <- data_o.
interface rv32im_lsu_if;
    logic        data_ready;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  word_size;
    logic        write;
    logic        clear;
    logic        req_active;
    logic        err;
    logic [31:0] rdata;

    modport master (
        output data_ready, addr, wdata, word_size, write, clear,
        input  req_active, err, rdata
    );

    modport slave (
        input  data_ready, addr, wdata, word_size, write, clear,
        output req_active, err, rdata
    );
endinterface

// File: rtl/rv32im_lsu.sv
// RV32 load/store sequencer: alignment trap, single-pulse issue to the memory
// stage, byte-lane replication for stores, extraction/extension for loads,
// and recovery of the memory stage after bus errors or timeouts.
module rv32im_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        clear_i,
    input  logic        req_i,
    input  logic        write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] fault_addr_o,
    output logic [31:0] rdata_o,
    rv32im_lsu_if.master mem
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

    typedef enum logic [2:0] {
        ST_RECOVER    = 3'd0,
        ST_IDLE       = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_WAIT_START = 3'd3,
        ST_WAIT_END   = 3'd4
    } state_t;

    // Replicate the right-justified store data across all byte lanes.
    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wd);
        logic [31:0] res;
        case (size)
            2'b00:   res = {4{wd[7:0]}};
            2'b01:   res = {2{wd[15:0]}};
            default: res = wd;
        endcase
        return res;
    endfunction

    // Align the addressed bytes to bit 0 and extend according to the width code.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh = word >> {off, 3'b000};
        case (f3)
            3'b000:  res = {{24{sh[7]}}, sh[7:0]};
            3'b001:  res = {{16{sh[15]}}, sh[15:0]};
            3'b100:  res = {24'h000000, sh[7:0]};
            3'b101:  res = {16'h0000, sh[15:0]};
            default: res = sh;
        endcase
        return res;
    endfunction

    state_t            state_r, state_nxt_s;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
    logic [1:0]        pend_r, pend_nxt_s;
    logic              req_write_r;
    logic [2:0]        req_funct3_r;
    logic [31:0]       req_addr_r;
    logic              latch_s;
    logic              bad_s;
    logic              done_r, done_nxt_s;
    logic [1:0]        err_code_r, err_code_nxt_s;
    logic [31:0]       fault_addr_r, fault_addr_nxt_s;
    logic [31:0]       rdata_r, rdata_nxt_s;
    logic              busy_r, mem_clear_r, mem_data_ready_r;
    logic [31:0]       mem_addr_r, mem_data_r;
    logic [1:0]        mem_word_size_r;
    logic              mem_write_r;

    // Width code legality and natural-alignment check on the incoming request.
    always_comb begin
        bad_s = 1'b0;
        if ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11) || (write_i && funct3_i[2])) begin
            bad_s = 1'b1;
        end else if ((funct3_i[1:0] == 2'b01) && addr_i[0]) begin
            bad_s = 1'b1;
        end else if ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00)) begin
            bad_s = 1'b1;
        end else begin
            bad_s = 1'b0;
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = '0;
        pend_nxt_s       = pend_r;
        latch_s          = 1'b0;
        done_nxt_s       = 1'b0;
        err_code_nxt_s   = 2'd0;
        fault_addr_nxt_s = fault_addr_r;
        rdata_nxt_s      = rdata_r;
        case (state_r)
            ST_RECOVER: begin
                state_nxt_s = ST_IDLE;
                if (pend_r != 2'd0) begin
                    done_nxt_s       = 1'b1;
                    err_code_nxt_s   = pend_r;
                    fault_addr_nxt_s = req_addr_r;
                    pend_nxt_s       = 2'd0;
                end else begin
                    pend_nxt_s = 2'd0;
                end
            end
            ST_IDLE: begin
                if (req_i && bad_s) begin
                    done_nxt_s       = 1'b1;
                    err_code_nxt_s   = 2'd1;
                    fault_addr_nxt_s = addr_i;
                end else if (req_i) begin
                    latch_s     = 1'b1;
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_nxt_s = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (mem.req_active) begin
                    state_nxt_s = ST_WAIT_END;
                    cnt_nxt_s   = cnt_r + CNT_ONE;
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RECOVER;
                    pend_nxt_s  = 2'd3;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            ST_WAIT_END: begin
                if (!mem.req_active && mem.err) begin
                    state_nxt_s = ST_RECOVER;
                    pend_nxt_s  = 2'd2;
                end else if (!mem.req_active) begin
                    state_nxt_s    = ST_IDLE;
                    done_nxt_s     = 1'b1;
                    err_code_nxt_s = 2'd0;
                    if (!req_write_r) begin
                        rdata_nxt_s = load_extend(req_funct3_r, req_addr_r[1:0], mem.rdata);
                    end else begin
                        rdata_nxt_s = rdata_r;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RECOVER;
                    pend_nxt_s  = 2'd3;
                end else begin
                    cnt_nxt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt_s = ST_RECOVER;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            state_r <= ST_RECOVER;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Counter, latched request, and registered outputs.
    always_ff @(posedge clk_i or posedge clear_i) begin
        if (clear_i) begin
            cnt_r            <= '0;
            pend_r           <= 2'd0;
            req_write_r      <= 1'b0;
            req_funct3_r     <= 3'd0;
            req_addr_r       <= 32'd0;
            done_r           <= 1'b0;
            err_code_r       <= 2'd0;
            fault_addr_r     <= 32'd0;
            rdata_r          <= 32'd0;
            busy_r           <= 1'b1;
            mem_clear_r      <= 1'b1;
            mem_data_ready_r <= 1'b0;
            mem_addr_r       <= 32'd0;
            mem_data_r       <= 32'd0;
            mem_word_size_r  <= 2'd0;
            mem_write_r      <= 1'b0;
        end else begin
            cnt_r            <= cnt_nxt_s;
            pend_r           <= pend_nxt_s;
            done_r           <= done_nxt_s;
            err_code_r       <= err_code_nxt_s;
            fault_addr_r     <= fault_addr_nxt_s;
            rdata_r          <= rdata_nxt_s;
            busy_r           <= (state_nxt_s != ST_IDLE);
            mem_clear_r      <= (state_nxt_s == ST_RECOVER);
            mem_data_ready_r <= (state_nxt_s == ST_ISSUE);
            if (latch_s) begin
                req_write_r     <= write_i;
                req_funct3_r    <= funct3_i;
                req_addr_r      <= addr_i;
                mem_addr_r      <= addr_i;
                mem_data_r      <= write_i ? store_lanes(funct3_i[1:0], wdata_i) : 32'd0;
                mem_word_size_r <= funct3_i[1:0];
                mem_write_r     <= write_i;
            end else begin
                req_write_r     <= req_write_r;
                req_funct3_r    <= req_funct3_r;
                req_addr_r      <= req_addr_r;
                mem_addr_r      <= mem_addr_r;
                mem_data_r      <= mem_data_r;
                mem_word_size_r <= mem_word_size_r;
                mem_write_r     <= mem_write_r;
            end
        end
    end

    assign busy_o         = busy_r;
    assign done_o         = done_r;
    assign err_code_o     = err_code_r;
    assign fault_addr_o   = fault_addr_r;
    assign rdata_o        = rdata_r;
    assign mem.data_ready = mem_data_ready_r;
    assign mem.addr       = mem_addr_r;
    assign mem.wdata      = mem_data_r;
    assign mem.word_size  = mem_word_size_r;
    assign mem.write      = mem_write_r;
    assign mem.clear      = mem_clear_r;

endmodule

// File: tb/tb_rv32im_lsu.sv
// Directed self-checking bench for rv32im_lsu with a cycle-scripted memory stage.
module tb_rv32im_lsu;
    logic        clk_i = 1'b0;
    logic        clear_i;
    logic        req_i;
    logic        write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  err_code_o;
    logic [31:0] fault_addr_o;
    logic [31:0] rdata_o;

    rv32im_lsu_if mem_if();

    rv32im_lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i        (clk_i),
        .clear_i      (clear_i),
        .req_i        (req_i),
        .write_i      (write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_code_o   (err_code_o),
        .fault_addr_o (fault_addr_o),
        .rdata_o      (rdata_o),
        .mem          (mem_if)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    // mode: 0 zero-wait ok, 1 bus error, 2 memory stage never responds
    task automatic access(input string tag, input logic w, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rword,
                          input int mode, input logic [31:0] exp_wlanes);
        int done_at;
        int dr_cnt;
        int clr_cnt;
        logic [1:0] exp_code;
        done_at  = -1;
        dr_cnt   = 0;
        clr_cnt  = 0;
        exp_code = (mode == 0) ? 2'd0 : ((mode == 1) ? 2'd2 : 2'd3);
        req_i = 1'b1; write_i = w; funct3_i = f3; addr_i = a; wdata_i = wd;
        step();
        req_i = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (mem_if.data_ready) dr_cnt++;
            if (mem_if.clear) clr_cnt++;
            if (c == 1) begin
                check_eq({tag, " busy"}, {31'd0, busy_o}, 32'd1);
                check_eq({tag, " maddr"}, mem_if.addr, a);
                check_eq({tag, " msize"}, {30'd0, mem_if.word_size}, {30'd0, f3[1:0]});
                check_eq({tag, " mwrite"}, {31'd0, mem_if.write}, {31'd0, w});
                if (w) check_eq({tag, " mdata"}, mem_if.wdata, exp_wlanes);
            end
            if (mode == 2 && c == 10) check_eq({tag, " clr_at10"}, {31'd0, mem_if.clear}, 32'd1);
            if (done_o) begin
                done_at = c;
                break;
            end
            case (c)
                2: if (mode != 2) mem_if.req_active = 1'b1;
                3: mem_if.rdata = rword;
                4: begin
                    mem_if.req_active = 1'b0;
                    mem_if.err = (mode == 1);
                end
                default: ;
            endcase
            step();
        end
        check_eq({tag, " done_at"}, 32'(done_at), (mode == 0) ? 32'd5 : ((mode == 1) ? 32'd6 : 32'd11));
        check_eq({tag, " code"}, {30'd0, err_code_o}, {30'd0, exp_code});
        check_eq({tag, " busy_done"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, " rdata"}, rdata_o, exp_rd);
        check_eq({tag, " dr_cycles"}, 32'(dr_cnt), 32'd1);
        check_eq({tag, " clr_cycles"}, 32'(clr_cnt), (mode == 0) ? 32'd0 : 32'd1);
        if (mode != 0) check_eq({tag, " fault"}, fault_addr_o, a);
        mem_if.err = 1'b0;
    endtask

    task automatic misal(input string tag, input logic w, input logic [2:0] f3, input logic [31:0] a);
        req_i = 1'b1; write_i = w; funct3_i = f3; addr_i = a; wdata_i = 32'h1111_2222;
        step();
        req_i = 1'b0;
        check_eq({tag, " done"}, {31'd0, done_o}, 32'd1);
        check_eq({tag, " code"}, {30'd0, err_code_o}, 32'd1);
        check_eq({tag, " busy"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, " dr"}, {31'd0, mem_if.data_ready}, 32'd0);
        check_eq({tag, " fault"}, fault_addr_o, a);
        check_eq({tag, " rdata"}, rdata_o, exp_rd);
        step();
        check_eq({tag, " done_after"}, {31'd0, done_o}, 32'd0);
        check_eq({tag, " dr_after"}, {31'd0, mem_if.data_ready}, 32'd0);
    endtask

    initial begin
        clear_i = 1'b1; req_i = 1'b0; write_i = 1'b0; funct3_i = 3'd0;
        addr_i = 32'd0; wdata_i = 32'd0;
        mem_if.req_active = 1'b0; mem_if.err = 1'b0; mem_if.rdata = 32'd0;
        exp_rd = 32'd0;
        step();
        step();
        check_eq("rst busy", {31'd0, busy_o}, 32'd1);
        check_eq("rst mclear", {31'd0, mem_if.clear}, 32'd1);
        check_eq("rst done", {31'd0, done_o}, 32'd0);
        check_eq("rst dr", {31'd0, mem_if.data_ready}, 32'd0);
        check_eq("rst rdata", rdata_o, 32'd0);
        clear_i = 1'b0;
        step();
        check_eq("post_rst busy", {31'd0, busy_o}, 32'd0);
        check_eq("post_rst mclear", {31'd0, mem_if.clear}, 32'd0);
        check_eq("post_rst done", {31'd0, done_o}, 32'd0);

        exp_rd = 32'hFFFF_FF80;
        access("lb", 1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_1234, 0, 32'd0);
        exp_rd = 32'h0000_8001;
        access("lhu", 1'b0, 3'b101, 32'h0000_0102, 32'd0, 32'h8001_7FFF, 0, 32'd0);
        access("sb", 1'b1, 3'b000, 32'h0000_0101, 32'h0000_005A, 32'd0, 0, 32'h5A5A_5A5A);
        access("sh", 1'b1, 3'b001, 32'h0000_0102, 32'hABCD_1234, 32'd0, 0, 32'h1234_1234);

        misal("lw_mis", 1'b0, 3'b010, 32'h0000_0102);
        misal("lh_mis", 1'b0, 3'b001, 32'h0000_0105);
        misal("sbu_ill", 1'b1, 3'b100, 32'h0000_0100);
        misal("f3_ill", 1'b0, 3'b011, 32'h0000_0108);

        access("sw_buserr", 1'b1, 3'b010, 32'h0000_0200, 32'hCAFE_F00D, 32'd0, 1, 32'hCAFE_F00D);
        exp_rd = 32'hDEAD_BEEF;
        access("lw_after", 1'b0, 3'b010, 32'h0000_0204, 32'd0, 32'hDEAD_BEEF, 0, 32'd0);
        check_eq("lw_after fault", fault_addr_o, 32'h0000_0200);
        access("lh_timeout", 1'b0, 3'b001, 32'h0000_0300, 32'd0, 32'd0, 2, 32'd0);
        exp_rd = 32'hFFFF_8000;
        access("lh_sign", 1'b0, 3'b001, 32'h0000_0106, 32'd0, 32'h8000_1234, 0, 32'd0);

        // Asynchronous clear while the memory stage is mid-transaction
        req_i = 1'b1; write_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_0108;
        step();
        req_i = 1'b0;
        step();
        mem_if.req_active = 1'b1;
        step();
        clear_i = 1'b1;
        #1;
        check_eq("clr busy", {31'd0, busy_o}, 32'd1);
        check_eq("clr mclear", {31'd0, mem_if.clear}, 32'd1);
        check_eq("clr done", {31'd0, done_o}, 32'd0);
        check_eq("clr dr", {31'd0, mem_if.data_ready}, 32'd0);
        check_eq("clr rdata", rdata_o, 32'd0);
        check_eq("clr fault", fault_addr_o, 32'd0);
        check_eq("clr maddr", mem_if.addr, 32'd0);
        exp_rd = 32'd0;
        @(negedge clk_i);
        clear_i = 1'b0;
        mem_if.req_active = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("clr no_done", {31'd0, done_o}, 32'd0);
        end
        exp_rd = 32'h1234_5678;
        access("lw_post_clr", 1'b0, 3'b010, 32'h0000_010C, 32'd0, 32'h1234_5678, 0, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
